// File: rtl/screensaver_pkg.sv
// ---------------------------------------------------------------------------
// screensaver_pkg
//   Shared definitions for the bouncing-sprite VGA core:
//     - default 640x480 timing and sprite constants
//     - colour index / RGB types, motion direction enum
//     - 8-entry 12-bit RGB palette (index 0 = red) and a lookup helper
//     - FLASH_FRAMES: length of the corner-hit background flash, used when
//       the core is built with SCREENSAVER_CORNER_FLASH_EN defined
// ---------------------------------------------------------------------------
package screensaver_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_SPRITE_W = 64;
    localparam int DEF_SPRITE_H = 32;
    localparam int DEF_SPEED    = 1;

    localparam int FLASH_FRAMES = 60;

    typedef logic [2:0]  colour_idx_t;
    typedef logic [11:0] rgb12_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam rgb12_t PALETTE [8] = '{
        12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
        12'h0FF, 12'h00F, 12'hF0F, 12'hFFF
    };

    function automatic rgb12_t palette_colour(input colour_idx_t idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Free-running horizontal/vertical counters with combinational decode of
//   the sync windows, the active region and the frame-level strobes.
//   Ports:
//     clk, rst          pixel clock, asynchronous active-high reset
//     hcount, vcount    current counter values (0..H_TOTAL-1 / 0..V_TOTAL-1)
//     active            inside the visible area
//     hsync, vsync      active-low sync levels for the current counters
//     frame_tick        hcount==0 on the first vertical blanking line
//     frame_first       counters at (0,0), the first pixel of a frame
// ---------------------------------------------------------------------------
module vga_timing
    import screensaver_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    parameter int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    parameter int HW       = $clog2(H_TOTAL),
    parameter int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_tick,
    output logic          frame_first
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] hcount_reg, hcount_next;
    logic [VW-1:0] vcount_reg, vcount_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    always_comb begin
        hcount_next = hcount_reg + 1'b1;
        vcount_next = vcount_reg;
        if (hcount_reg == HW'(H_TOTAL - 1)) begin
            hcount_next = '0;
            if (vcount_reg == VW'(V_TOTAL - 1)) begin
                vcount_next = '0;
            end else begin
                vcount_next = vcount_reg + 1'b1;
            end
        end
    end

    // One extra bit so window ends equal to 2**W still compare correctly.
    logic [HW:0] hcount_ext;
    logic [VW:0] vcount_ext;
    assign hcount_ext = {1'b0, hcount_reg};
    assign vcount_ext = {1'b0, vcount_reg};

    assign hcount      = hcount_reg;
    assign vcount      = vcount_reg;
    assign active      = (hcount_ext < (HW+1)'(H_ACTIVE)) && (vcount_ext < (VW+1)'(V_ACTIVE));
    assign hsync       = !((hcount_ext >= (HW+1)'(HS_START)) && (hcount_ext < (HW+1)'(HS_END)));
    assign vsync       = !((vcount_ext >= (VW+1)'(VS_START)) && (vcount_ext < (VW+1)'(VS_END)));
    assign frame_tick  = (hcount_reg == '0) && (vcount_ext == (VW+1)'(V_ACTIVE));
    assign frame_first = (hcount_reg == '0) && (vcount_reg == '0);

endmodule

// File: rtl/vga_bounce_core.sv
// ---------------------------------------------------------------------------
// vga_bounce_core
//   VGA timing plus a rectangular sprite bouncing off the screen edges.
//   Every frame in which the sprite hits a wall advances the palette colour
//   and the bounce counter (once per frame, corners included).
//   Ports:
//     clk_25_175     pixel clock
//     rst            asynchronous active-high reset
//     enable         motion enable, sampled once per frame at frame_tick
//     hsync, vsync   active-low syncs (registered)
//     r, g, b        4-bit colour channels (registered)
//     frame_start    one-cycle pulse with output pixel (0,0)
//     bounce_count   frames containing a wall hit, wraps at 256
//   Build option:
//     SCREENSAVER_CORNER_FLASH_EN  corner hits turn the background white
//                                  for FLASH_FRAMES frames
// ---------------------------------------------------------------------------
module vga_bounce_core
    import screensaver_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SPRITE_W = DEF_SPRITE_W,
    parameter int SPRITE_H = DEF_SPRITE_H,
    parameter int SPEED    = DEF_SPEED
) (
    input  logic       clk_25_175,
    input  logic       rst,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       frame_start,
    output logic [7:0] bounce_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XMAX    = H_ACTIVE - SPRITE_W;
    localparam int YMAX    = V_ACTIVE - SPRITE_H;
    // Common position width for both axes, one bit of headroom for pos+step.
    localparam int PW      = ((HW > VW) ? HW : VW) + 1;

    // ------------------------------------------------------------------
    // Timing
    // ------------------------------------------------------------------
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          active;
    logic          hsync_next;
    logic          vsync_next;
    logic          frame_tick;
    logic          frame_start_next;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk_25_175),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .hsync       (hsync_next),
        .vsync       (vsync_next),
        .frame_tick  (frame_tick),
        .frame_first (frame_start_next)
    );

    // ------------------------------------------------------------------
    // Motion: axis 0 = x, axis 1 = y
    // ------------------------------------------------------------------
    logic [PW-1:0] pos_reg  [2];
    logic [PW-1:0] pos_next [2];
    dir_t          dir_reg  [2];
    dir_t          dir_next [2];
    logic [1:0]    hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [PW-1:0] AXIS_MAX = (gi == 0) ? PW'(XMAX) : PW'(YMAX);
            localparam logic [PW-1:0] STEP     = PW'(SPEED);

            logic [PW-1:0] axis_pos_next;
            dir_t          axis_dir_next;
            logic          axis_hit;

            // Overshoot is clamped to the wall, so the sprite always
            // touches the edge exactly on the frame it bounces.
            always_comb begin
                axis_pos_next = pos_reg[gi];
                axis_dir_next = dir_reg[gi];
                axis_hit      = 1'b0;
                if (dir_reg[gi] == DIR_POS) begin
                    if (pos_reg[gi] + STEP >= AXIS_MAX) begin
                        axis_pos_next = AXIS_MAX;
                        axis_dir_next = DIR_NEG;
                        axis_hit      = 1'b1;
                    end else begin
                        axis_pos_next = pos_reg[gi] + STEP;
                    end
                end else begin
                    if (pos_reg[gi] <= STEP) begin
                        axis_pos_next = '0;
                        axis_dir_next = DIR_POS;
                        axis_hit      = 1'b1;
                    end else begin
                        axis_pos_next = pos_reg[gi] - STEP;
                    end
                end
            end

            assign pos_next[gi] = axis_pos_next;
            assign dir_next[gi] = axis_dir_next;
            assign hit[gi]      = axis_hit;
        end
    endgenerate

    logic        move;
    logic        any_hit;
    colour_idx_t colour_reg;
    logic [7:0]  bounce_reg;

    assign move    = frame_tick && enable;
    assign any_hit = |hit;

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pos_reg[i] <= '0;
                dir_reg[i] <= DIR_POS;
            end
            colour_reg <= '0;
            bounce_reg <= '0;
        end else if (move) begin
            for (int i = 0; i < 2; i++) begin
                pos_reg[i] <= pos_next[i];
                dir_reg[i] <= dir_next[i];
            end
            if (any_hit) begin
                colour_reg <= colour_reg + 1'b1;
                bounce_reg <= bounce_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Corner flash
    // ------------------------------------------------------------------
    logic flash_on;

`ifdef SCREENSAVER_CORNER_FLASH_EN
    logic [5:0] flash_reg;

    // Counts down every frame even while motion is frozen; a fresh
    // corner hit restarts the count.
    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            flash_reg <= '0;
        end else if (frame_tick) begin
            if (move && (&hit)) begin
                flash_reg <= 6'(FLASH_FRAMES);
            end else if (flash_reg != '0) begin
                flash_reg <= flash_reg - 1'b1;
            end
        end
    end

    assign flash_on = (flash_reg != '0);
`else
    assign flash_on = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pixel generation
    // ------------------------------------------------------------------
    logic [PW-1:0] hpos;
    logic [PW-1:0] vpos;
    logic          in_sprite;
    rgb12_t        pixel_next;

    assign hpos = PW'(hcount);
    assign vpos = PW'(vcount);

    assign in_sprite = (hpos >= pos_reg[0]) && (hpos < pos_reg[0] + PW'(SPRITE_W)) &&
                       (vpos >= pos_reg[1]) && (vpos < pos_reg[1] + PW'(SPRITE_H));

    always_comb begin
        pixel_next = '0;
        if (active) begin
            if (in_sprite) begin
                pixel_next = palette_colour(colour_reg);
            end else if (flash_on) begin
                pixel_next = 12'hFFF;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: syncs, colour and frame_start share one cycle of
    // latency from the counters so they stay mutually aligned.
    // ------------------------------------------------------------------
    logic   hsync_reg;
    logic   vsync_reg;
    logic   frame_start_reg;
    rgb12_t rgb_reg;

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
            rgb_reg         <= '0;
        end else begin
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            frame_start_reg <= frame_start_next;
            rgb_reg         <= pixel_next;
        end
    end

    assign hsync        = hsync_reg;
    assign vsync        = vsync_reg;
    assign frame_start  = frame_start_reg;
    assign r            = rgb_reg[11:8];
    assign g            = rgb_reg[7:4];
    assign b            = rgb_reg[3:0];
    assign bounce_count = bounce_reg;

endmodule

// File: tb/tb_vga_bounce_core.sv
// ---------------------------------------------------------------------------
// tb_vga_bounce_core
//   Small-geometry bench (16x16 visible, 22x19 total, 4x4 sprite, speed 3).
//   A frame-level model (position, direction, colour, bounce count, flash)
//   predicts every output pixel/sync value; motion enable is randomised per
//   frame after a deterministic bounce, corner and freeze sequence, and an
//   asynchronous reset is applied mid-line.
// ---------------------------------------------------------------------------
module tb_vga_bounce_core;

    localparam int HA = 16, HF = 2, HS = 2, HB = 2;
    localparam int VA = 16, VF = 1, VS = 1, VB = 1;
    localparam int SW = 4, SH = 4, SPD = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME  = HT * VT;
    localparam int XMAX   = HA - SW;
    localparam int YMAX   = VA - SH;
    localparam int TICK_P = VA * HT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       hsync, vsync, frame_start;
    logic [3:0] r, g, b;
    logic [7:0] bounce_count;

    always #5 clk = ~clk;

    vga_bounce_core #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SPRITE_W (SW), .SPRITE_H (SH), .SPEED (SPD)
    ) dut (
        .clk_25_175   (clk),
        .rst          (rst),
        .enable       (enable),
        .hsync        (hsync),
        .vsync        (vsync),
        .r            (r),
        .g            (g),
        .b            (b),
        .frame_start  (frame_start),
        .bounce_count (bounce_count)
    );

    logic [11:0] pal [8] = '{12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                             12'h0FF, 12'h00F, 12'hF0F, 12'hFFF};

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference state.
    int mx, my, mdx, mdy, mcol, mbounce, mflash;
    int p_cnt;
    int frame_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1;
        mcol = 0; mbounce = 0; mflash = 0;
        p_cnt = 0;
    endtask

    task automatic model_tick(input bit en);
        bit hx, hy;
        int n;
        hx = 0; hy = 0;
        if (en) begin
            n = mx + mdx * SPD;
            if (n >= XMAX)   begin mx = XMAX; mdx = -1; hx = 1; end
            else if (n <= 0) begin mx = 0;    mdx = 1;  hx = 1; end
            else mx = n;
            n = my + mdy * SPD;
            if (n >= YMAX)   begin my = YMAX; mdy = -1; hy = 1; end
            else if (n <= 0) begin my = 0;    mdy = 1;  hy = 1; end
            else my = n;
            if (hx || hy) begin
                mcol    = (mcol + 1) % 8;
                mbounce = (mbounce + 1) % 256;
            end
        end
`ifdef SCREENSAVER_CORNER_FLASH_EN
        if (en && hx && hy) mflash = 60;
        else if (mflash > 0) mflash--;
`endif
    endtask

    // Expected {hsync, vsync, frame_start, rgb} for output pixel index p.
    function automatic logic [31:0] exp_out(input int p);
        int h, v;
        logic hs_e, vs_e, fs_e;
        logic [11:0] pix;
        h = p % HT;
        v = p / HT;
        hs_e = !(h >= HA + HF && h < HA + HF + HS);
        vs_e = !(v >= VA + VF && v < VA + VF + VS);
        fs_e = (p == 0);
        pix = 12'h000;
        if (h < HA && v < VA) begin
            if (h >= mx && h < mx + SW && v >= my && v < my + SH) pix = pal[mcol];
            else if (mflash > 0) pix = 12'hFFF;
        end
        return {17'b0, hs_e, vs_e, fs_e, pix};
    endfunction

    function automatic logic [31:0] dut_out();
        return {17'b0, hsync, vsync, frame_start, r, g, b};
    endfunction

    task automatic run_cycle(output int p);
        bit en_edge;
        @(posedge clk);
        p = p_cnt;
        p_cnt = (p_cnt + 1) % FRAME;
        en_edge = enable;
        @(negedge clk);
        check($sformatf("pix f=%0d p=%0d", frame_no, p), dut_out(), exp_out(p));
        if (p == 0) begin
            check($sformatf("bounce f=%0d", frame_no), 32'(bounce_count), 32'(mbounce));
            $display("frame %0d: pos=(%0d,%0d) colour=%0d bounce=%0d en=%0b",
                     frame_no, mx, my, mcol, mbounce, enable);
            frame_no++;
        end
        if (p == TICK_P) model_tick(en_edge);
    endtask

    // mode 0: enable=1, mode 1: enable=0, mode 2: random; applied at frame start.
    task automatic run_cycles(input int n, input int mode);
        int p;
        for (int i = 0; i < n; i++) begin
            run_cycle(p);
            if (p == 0) begin
                case (mode)
                    0:       enable = 1'b1;
                    1:       enable = 1'b0;
                    default: enable = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    endtask

    logic [11:0] bg_exp;

    initial begin
        model_reset();
        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_out", dut_out(), 32'h0000_6000);
        check("reset_bounce", 32'(bounce_count), 32'd0);

        // Release and run to pixel (7,6) of frame 2: sprite there at (6,6).
        rst = 1'b0;
        model_reset();
        run_cycles(2 * FRAME + 6 * HT + 7 + 1, 0);
        check("pre_rst_sprite", 32'({r, g, b}), 32'h0000_0F00);

        // Asynchronous reset mid-line: outputs must clear before any edge.
        #1 rst = 1'b1;
        #1 check("async_rst_out", dut_out(), 32'h0000_6000);
        check("async_rst_bounce", 32'(bounce_count), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_out", dut_out(), 32'h0000_6000);
        rst = 1'b0;
        model_reset();
        frame_no = 0;

        // First pixel after release: sprite at origin in palette colour 0.
        run_cycles(1, 0);
        check("origin_pixel", 32'({r, g, b}), 32'h0000_0F00);
        check("origin_fs", 32'(frame_start), 32'd1);

        // Four ticks: 3,6,9,12 -> corner hit on both axes, one bounce.
        run_cycles(4 * FRAME, 0);
        check("corner_bounce", 32'(bounce_count), 32'd1);
`ifdef SCREENSAVER_CORNER_FLASH_EN
        bg_exp = 12'hFFF;
`else
        bg_exp = 12'h000;
`endif
        check("corner_bg", 32'({r, g, b}), 32'(bg_exp));

        // Back to origin: 9,6,3,0 -> second bounce.
        run_cycles(4 * FRAME, 0);
        check("return_bounce", 32'(bounce_count), 32'd2);
        run_cycles(2 * FRAME, 0);

        // Freeze across three frame ticks.
        enable = 1'b0;
        run_cycles(3 * FRAME, 1);
        check("freeze_bounce", 32'(bounce_count), 32'd2);

        // Randomised enable, long enough to see the flash expire.
        run_cycles(64 * FRAME, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
